// File: rtl/dual_port_ssram_be.sv
// Dual-port synchronous SRAM with per-byte write enables, selectable same-port and
// cross-port read-during-write behaviour, and an optional output register stage.
module dual_port_ssram_be #(
   parameter int bitwidth       = 32,
   parameter int nrOfEntries    = 512,
   parameter int readAfterWrite = 0,
   parameter int outputRegister = 0,
   parameter int crossBypass    = 0
) (
   input  logic                           clock,
   input  logic                           resetN,
   input  logic                           enableA,
   input  logic                           enableB,
   input  logic                           writeEnableA,
   input  logic                           writeEnableB,
   input  logic [bitwidth/8-1:0]          byteEnableA,
   input  logic [bitwidth/8-1:0]          byteEnableB,
   input  logic [$clog2(nrOfEntries)-1:0] addressA,
   input  logic [$clog2(nrOfEntries)-1:0] addressB,
   input  logic [bitwidth-1:0]            dataInA,
   input  logic [bitwidth-1:0]            dataInB,
   output logic [bitwidth-1:0]            dataOutA,
   output logic [bitwidth-1:0]            dataOutB,
   output logic                           dataValidA,
   output logic                           dataValidB,
   output logic                           collision
);
   localparam int nrOfBytes = bitwidth / 8;
   localparam int addrWidth = $clog2(nrOfEntries);

   function automatic logic [bitwidth-1:0] byteMask(input logic [nrOfBytes-1:0] be);
      logic [bitwidth-1:0] m;
      m = '0;
      for (int i = 0; i < nrOfBytes; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   logic [bitwidth-1:0]  memory [nrOfEntries];
   logic [bitwidth-1:0]  ramA, ramB;
   logic                 inRangeA, inRangeB, writeA, writeB, sameAddr;
   logic [addrWidth-1:0] readIndexA, readIndexB;
   logic [nrOfBytes-1:0] visAtoA, visBtoA, visAtoB, visBtoB;

   assign inRangeA   = 32'(addressA) < 32'(nrOfEntries);
   assign inRangeB   = 32'(addressB) < 32'(nrOfEntries);
   assign writeA     = resetN & enableA & writeEnableA & inRangeA;
   assign writeB     = resetN & enableB & writeEnableB & inRangeB;
   assign sameAddr   = addressA == addressB;
   assign readIndexA = inRangeA ? addressA : '0;
   assign readIndexB = inRangeB ? addressB : '0;

   // Which port's freshly written bytes each port's read result must reflect.
   always_comb begin
      visAtoA = '0;
      visBtoA = '0;
      visAtoB = '0;
      visBtoB = '0;
      if (readAfterWrite == 0) begin
         if (writeA) visAtoA = byteEnableA;
         if (writeB) visBtoB = byteEnableB;
      end
      if (crossBypass != 0 && sameAddr) begin
         if (writeB) visBtoA = byteEnableB;
         if (writeA) visAtoB = byteEnableA;
      end
   end

   // Read-first array; B is written before A so A owns any byte both ports enable.
   always_ff @(posedge clock) begin
      if (enableA) ramA <= memory[readIndexA];
      if (enableB) ramB <= memory[readIndexB];
      for (int i = 0; i < nrOfBytes; i++) begin
         if (writeB && byteEnableB[i]) memory[addressB][8*i +: 8] <= dataInB[8*i +: 8];
         if (writeA && byteEnableA[i]) memory[addressA][8*i +: 8] <= dataInA[8*i +: 8];
      end
   end

   logic [bitwidth-1:0] ovlMaskA, ovlDataA, ovlMaskB, ovlDataB;
   logic                inRangeA1, inRangeB1, validA1, validB1;
   logic [bitwidth-1:0] mergedA, mergedB;

   // dataValid is a one-cycle strobe with no backpressure: every accepted access yields exactly one.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         validA1   <= 1'b0;
         validB1   <= 1'b0;
         inRangeA1 <= 1'b0;
         inRangeB1 <= 1'b0;
         ovlMaskA  <= '0;
         ovlDataA  <= '0;
         ovlMaskB  <= '0;
         ovlDataB  <= '0;
         collision <= 1'b0;
      end else begin
         validA1   <= enableA;
         validB1   <= enableB;
         collision <= writeA & writeB & sameAddr & (|(byteEnableA & byteEnableB));
         if (enableA) begin
            inRangeA1 <= inRangeA;
            ovlMaskA  <= byteMask(visAtoA | visBtoA);
            ovlDataA  <= (dataInA & byteMask(visAtoA)) | (dataInB & ~byteMask(visAtoA));
         end
         if (enableB) begin
            inRangeB1 <= inRangeB;
            ovlMaskB  <= byteMask(visAtoB | visBtoB);
            ovlDataB  <= (dataInA & byteMask(visAtoB)) | (dataInB & ~byteMask(visAtoB));
         end
      end
   end

   // Out-of-range or post-reset state reads as zero through inRange*1.
   assign mergedA = inRangeA1 ? ((ramA & ~ovlMaskA) | (ovlDataA & ovlMaskA)) : '0;
   assign mergedB = inRangeB1 ? ((ramB & ~ovlMaskB) | (ovlDataB & ovlMaskB)) : '0;

   generate
      if (outputRegister != 0) begin : g_outReg
         logic [bitwidth-1:0] outA, outB;
         logic                validA2, validB2;
         always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
               outA    <= '0;
               outB    <= '0;
               validA2 <= 1'b0;
               validB2 <= 1'b0;
            end else begin
               validA2 <= validA1;
               validB2 <= validB1;
               if (validA1) outA <= mergedA;
               if (validB1) outB <= mergedB;
            end
         end
         assign dataOutA   = outA;
         assign dataOutB   = outB;
         assign dataValidA = validA2;
         assign dataValidB = validB2;
      end else begin : g_noOutReg
         assign dataOutA   = mergedA;
         assign dataOutB   = mergedB;
         assign dataValidA = validA1;
         assign dataValidB = validB1;
      end
   endgenerate
endmodule

// File: tb/tb_dual_port_ssram_be.sv
// Bench for dual_port_ssram_be: two instances with contrasting parameters share one
// stimulus stream and are scored against a word/byte-level memory model.
module tb_dual_port_ssram_be;
   logic        clock = 1'b0;
   logic        resetN = 1'b1;
   logic        enA, enB, weA, weB;
   logic [3:0]  beA, beB;
   logic [8:0]  adA, adB;
   logic [31:0] dinA, dinB;
   logic [31:0] doutA [2];
   logic [31:0] doutB [2];
   logic        dvA [2];
   logic        dvB [2];
   logic        coll [2];

   dual_port_ssram_be #(.bitwidth(32), .nrOfEntries(512), .readAfterWrite(0),
                        .outputRegister(0), .crossBypass(0)) dut0 (
      .clock(clock), .resetN(resetN),
      .enableA(enA), .enableB(enB), .writeEnableA(weA), .writeEnableB(weB),
      .byteEnableA(beA), .byteEnableB(beB), .addressA(adA), .addressB(adB),
      .dataInA(dinA), .dataInB(dinB), .dataOutA(doutA[0]), .dataOutB(doutB[0]),
      .dataValidA(dvA[0]), .dataValidB(dvB[0]), .collision(coll[0]));

   dual_port_ssram_be #(.bitwidth(32), .nrOfEntries(500), .readAfterWrite(1),
                        .outputRegister(1), .crossBypass(1)) dut1 (
      .clock(clock), .resetN(resetN),
      .enableA(enA), .enableB(enB), .writeEnableA(weA), .writeEnableB(weB),
      .byteEnableA(beA), .byteEnableB(beB), .addressA(adA), .addressB(adB),
      .dataInA(dinA), .dataInB(dinB), .dataOutA(doutA[1]), .dataOutB(doutB[1]),
      .dataValidA(dvA[1]), .dataValidB(dvB[1]), .collision(coll[1]));

   always #5 clock = ~clock;

   // Instance parameters as the model sees them.
   int rawP   [2] = '{0, 1};
   int cbP    [2] = '{0, 1};
   int latP   [2] = '{1, 2};
   int depthP [2] = '{512, 500};

   logic [31:0] mem_m [2][512];
   logic [31:0] exp_q [4][$];
   int          due_q [4][$];
   logic [31:0] hold [4];
   logic        coll_next [2];
   logic        coll_exp [2];
   int          en_cnt [4];
   int          val_cnt [4];
   int          edge_cnt = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [3:0] be,
                                               input logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Model of one clock edge given the inputs currently driven.
   task automatic model_edge();
      logic        en [2];
      logic        we [2];
      logic [3:0]  be [2];
      logic [8:0]  ad [2];
      logic [31:0] dn [2];
      en = '{enA, enB}; we = '{weA, weB}; be = '{beA, beB}; ad = '{adA, adB}; dn = '{dinA, dinB};
      for (int k = 0; k < 2; k++) begin
         logic        inr [2];
         logic        wr [2];
         logic [31:0] res;
         for (int p = 0; p < 2; p++) begin
            inr[p] = int'(ad[p]) < depthP[k];
            wr[p]  = resetN && en[p] && we[p] && inr[p];
         end
         for (int p = 0; p < 2; p++) begin
            if (resetN && en[p]) begin
               res = 32'h0;
               if (inr[p]) begin
                  res = mem_m[k][ad[p]];
                  if (wr[1] && ((p == 1) ? (rawP[k] == 0) : (cbP[k] == 1 && ad[0] == ad[1])))
                     res = merge_bytes(res, be[1], dn[1]);
                  if (wr[0] && ((p == 0) ? (rawP[k] == 0) : (cbP[k] == 1 && ad[0] == ad[1])))
                     res = merge_bytes(res, be[0], dn[0]);
               end
               exp_q[k*2+p].push_back(res);
               due_q[k*2+p].push_back(edge_cnt + latP[k]);
               en_cnt[k*2+p]++;
            end
         end
         coll_next[k] = wr[0] && wr[1] && ad[0] == ad[1] && (be[0] & be[1]) != 4'h0;
         if (wr[1]) mem_m[k][ad[1]] = merge_bytes(mem_m[k][ad[1]], be[1], dn[1]);
         if (wr[0]) mem_m[k][ad[0]] = merge_bytes(mem_m[k][ad[0]], be[0], dn[0]);
      end
   endtask

   task automatic check_outputs();
      for (int s = 0; s < 4; s++) begin
         int          k;
         logic        exp_v, got_v;
         logic [31:0] got_d;
         string       nm;
         k = s / 2;
         nm = $sformatf("i%0d_%s", k, (s % 2 == 1) ? "B" : "A");
         exp_v = due_q[s].size() > 0 && due_q[s][0] == edge_cnt;
         if (exp_v) begin
            hold[s] = exp_q[s].pop_front();
            void'(due_q[s].pop_front());
         end
         got_v = (s % 2 == 1) ? dvB[k] : dvA[k];
         got_d = (s % 2 == 1) ? doutB[k] : doutA[k];
         if (got_v) val_cnt[s]++;
         check_eq({nm, "_valid"}, 32'(got_v), 32'(exp_v));
         check_eq({nm, "_data"}, got_d, hold[s]);
      end
      for (int k = 0; k < 2; k++)
         check_eq($sformatf("i%0d_collision", k), 32'(coll[k]), 32'(coll_exp[k]));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clock);
      edge_cnt++;
      for (int k = 0; k < 2; k++) coll_exp[k] = coll_next[k];
      @(negedge clock);
      check_outputs();
   endtask

   task automatic assert_reset();
      resetN = 1'b0;
      for (int s = 0; s < 4; s++) begin
         en_cnt[s] -= exp_q[s].size();
         exp_q[s].delete();
         due_q[s].delete();
         hold[s] = 32'h0;
      end
      for (int k = 0; k < 2; k++) coll_exp[k] = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("rst_now_i%0d_doutA", k), doutA[k], 32'h0);
         check_eq($sformatf("rst_now_i%0d_doutB", k), doutB[k], 32'h0);
      end
   endtask

   task automatic drive_a(input logic en, input logic we, input logic [3:0] be,
                          input logic [8:0] ad, input logic [31:0] d);
      enA = en; weA = we; beA = be; adA = ad; dinA = d;
   endtask

   task automatic drive_b(input logic en, input logic we, input logic [3:0] be,
                          input logic [8:0] ad, input logic [31:0] d);
      enB = en; weB = we; beB = be; adB = ad; dinB = d;
   endtask

   task automatic idle();
      drive_a(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
      drive_b(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
   endtask

   function automatic logic [8:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) return 9'($urandom_range(0, 7));
      if (r < 8) return 9'($urandom_range(0, 511));
      return 9'($urandom_range(496, 511));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 4; s++) begin
         hold[s] = 32'h0; en_cnt[s] = 0; val_cnt[s] = 0;
      end
      for (int k = 0; k < 2; k++) begin
         coll_exp[k] = 1'b0; coll_next[k] = 1'b0;
      end
      idle();
      #1;
      assert_reset();
      repeat (2) cycle();
      resetN = 1'b1;

      // Fill every word so the model and both arrays start from known content.
      for (int i = 0; i < 256; i++) begin
         drive_a(1'b1, 1'b1, 4'hF, 9'(i), $urandom);
         drive_b(1'b1, 1'b1, 4'hF, 9'(i + 256), $urandom);
         cycle();
      end
      idle();
      repeat (2) cycle();

      // Full-word write then cross-port read.
      drive_a(1'b1, 1'b1, 4'hF, 9'd5, 32'hDEADBEEF); cycle();
      idle(); drive_b(1'b1, 1'b0, 4'h0, 9'd5, 32'h0); cycle();
      check_eq("r030_lat1_doutB", doutB[0], 32'hDEADBEEF);
      idle(); cycle();
      check_eq("r030_lat2_doutB", doutB[1], 32'hDEADBEEF);

      // Partial byte write.
      drive_a(1'b1, 1'b1, 4'hF, 9'd7, 32'h11223344); cycle();
      drive_a(1'b1, 1'b1, 4'b0101, 9'd7, 32'hAABBCCDD); cycle();
      idle(); drive_b(1'b1, 1'b0, 4'h0, 9'd7, 32'h0); cycle();
      idle(); cycle();
      check_eq("r031_i0_doutB", doutB[0], 32'h11BB33DD);
      check_eq("r031_i1_doutB", doutB[1], 32'h11BB33DD);

      // Same-port and cross-port read-during-write.
      drive_a(1'b1, 1'b1, 4'hF, 9'd3, 32'h0); cycle();
      drive_a(1'b1, 1'b1, 4'hF, 9'd3, 32'h12345678);
      drive_b(1'b1, 1'b0, 4'h0, 9'd3, 32'h0); cycle();
      idle(); cycle();
      check_eq("r032_i0_crossB", doutB[0], 32'h0);
      check_eq("r032_i0_sameA", doutA[0], 32'h12345678);
      check_eq("r032_i1_crossB", doutB[1], 32'h12345678);
      check_eq("r032_i1_sameA", doutA[1], 32'h0);

      // Dual write, same address, overlapping byte 1.
      drive_a(1'b1, 1'b1, 4'b0011, 9'd9, 32'hAAAAAAAA);
      drive_b(1'b1, 1'b1, 4'b1110, 9'd9, 32'hBBBBBBBB); cycle();
      check_eq("r033_i0_coll_set", 32'(coll[0]), 32'd1);
      check_eq("r033_i1_coll_set", 32'(coll[1]), 32'd1);
      idle(); cycle();
      check_eq("r033_i0_coll_clr", 32'(coll[0]), 32'd0);
      drive_a(1'b1, 1'b0, 4'h0, 9'd9, 32'h0); cycle();
      idle(); cycle();
      check_eq("r033_i0_word", doutA[0], 32'hBBBBAAAA);
      check_eq("r033_i1_word", doutA[1], 32'hBBBBAAAA);

      // Reset while a latency-2 read is in flight; a write during reset is ignored.
      drive_a(1'b1, 1'b0, 4'h0, 9'd5, 32'h0); cycle();
      drive_a(1'b1, 1'b1, 4'hF, 9'd5, 32'h0);
      assert_reset();
      cycle();
      resetN = 1'b1;
      idle(); repeat (2) cycle();
      check_eq("r034_i1_doutA_after", doutA[1], 32'h0);
      drive_a(1'b1, 1'b0, 4'h0, 9'd5, 32'h0); cycle();
      idle(); cycle();
      check_eq("r034_i0_reread", doutA[0], 32'hDEADBEEF);
      check_eq("r034_i1_reread", doutA[1], 32'hDEADBEEF);

      // Random traffic on both ports with one reset in the middle.
      for (int s = 0; s < 4; s++) begin
         en_cnt[s] = 0; val_cnt[s] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         if (c == 5000) assert_reset();
         if (c == 5002) resetN = 1'b1;
         drive_a($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rand_addr(), $urandom);
         drive_b($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rand_addr(), $urandom);
         cycle();
      end
      idle();
      repeat (3) cycle();
      for (int s = 0; s < 4; s++)
         check_eq($sformatf("valid_count_s%0d", s), 32'(val_cnt[s]), 32'(en_cnt[s]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
